// File: rtl/bit_unpacker.sv
// Bit unpacker: refills a 64-bit left-justified bit buffer from a 32-bit word FIFO and
// serves variable-length (0..15 bit) MSB-first read requests.
module bit_unpacker #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned BUF_W  = 64,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned OUT_W  = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [WORD_W-1:0] fifo_data,
    output logic              fifo_pop,
    input  logic              reqin,
    input  logic [LEN_W-1:0]  reqlen,
    output logic              req_busy,
    output logic              pushout,
    output logic [LEN_W-1:0]  lenout,
    output logic [OUT_W-1:0]  dataout,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(BUF_W + 1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e             state_q, state_d;
    logic [BUF_W-1:0]   bit_buf_q, bit_buf_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               pend_q, pend_d;
    logic               pop_q, pop_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               push_q, push_d;
    logic [LEN_W-1:0]   lenout_q, lenout_d;
    logic [OUT_W-1:0]   data_q, data_d;
    logic               err_q, err_d;

    logic               grant;
    logic [LEN_W-1:0]   cur_len;
    logic [LEN_W-1:0]   shamt;
    logic [BUF_W-1:0]   consumed_buf;
    logic [CNT_W-1:0]   consumed_cnt;

    // Request FSM: decides whether a grant happens this cycle and with which length.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        err_d   = err_q;
        grant   = 1'b0;
        cur_len = len_q;
        unique case (state_q)
            StIdle: begin
                if (reqin) begin
                    cur_len = reqlen;
                    len_d   = reqlen;
                    if (bit_cnt_q >= CNT_W'(reqlen)) begin
                        grant = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (reqin) begin
                    err_d = 1'b1;
                end
                if (bit_cnt_q >= CNT_W'(len_q)) begin
                    grant   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Buffer datapath: consume first, then drop the refill word in right behind the
    // remaining bits.
    always_comb begin
        consumed_buf = bit_buf_q;
        consumed_cnt = bit_cnt_q;
        if (grant) begin
            consumed_buf = bit_buf_q << cur_len;
            consumed_cnt = bit_cnt_q - CNT_W'(cur_len);
        end

        bit_buf_d = consumed_buf;
        bit_cnt_d = consumed_cnt;
        if (pend_q) begin
            bit_buf_d = consumed_buf | ({fifo_data, {(BUF_W - WORD_W){1'b0}}} >> consumed_cnt);
            bit_cnt_d = consumed_cnt + CNT_W'(WORD_W);
        end

        // A pop is only issued when no word is in flight, so the buffer never overflows.
        pend_d = pop_q;
        pop_d  = !pop_q && !pend_q && !fifo_empty && (bit_cnt_d <= CNT_W'(WORD_W));
    end

    always_comb begin
        shamt    = LEN_W'(OUT_W) - cur_len;
        push_d   = grant;
        lenout_d = '0;
        data_d   = '0;
        if (grant) begin
            lenout_d = cur_len;
            data_d   = bit_buf_q[BUF_W-1 -: OUT_W] >> shamt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            bit_buf_q <= '0;
            bit_cnt_q <= '0;
            pend_q    <= 1'b0;
            pop_q     <= 1'b0;
            len_q     <= '0;
            push_q    <= 1'b0;
            lenout_q  <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_buf_q <= bit_buf_d;
            bit_cnt_q <= bit_cnt_d;
            pend_q    <= pend_d;
            pop_q     <= pop_d;
            len_q     <= len_d;
            push_q    <= push_d;
            lenout_q  <= lenout_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    assign fifo_pop = pop_q;
    assign req_busy = (state_q == StWait);
    assign pushout  = push_q;
    assign lenout   = lenout_q;
    assign dataout  = data_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bit_unpacker.sv
// Self-checking bench for bit_unpacker: directed vector tables plus a randomized stream
// compared against a bit-queue reference model.
module tb_bit_unpacker;

    typedef struct packed {
        logic [3:0]  len;
        logic [14:0] data;
    } rsp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data = '0;
    logic        fifo_pop;
    logic        reqin = 1'b0;
    logic [3:0]  reqlen = '0;
    logic        req_busy;
    logic        pushout;
    logic [3:0]  lenout;
    logic [14:0] dataout;
    logic        err;

    logic [31:0] fq[$];
    bit          model_bits[$];
    rsp_t        exp_q[$];
    int          popped_words = 0;
    int          consumed = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    bit_unpacker dut (
        .clock      (clock),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .reqin      (reqin),
        .reqlen     (reqlen),
        .req_busy   (req_busy),
        .pushout    (pushout),
        .lenout     (lenout),
        .dataout    (dataout),
        .err        (err)
    );

    always #5 clock = ~clock;

    // FIFO with registered read data and registered empty flag.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            fq.delete();
            fifo_empty   <= 1'b1;
            fifo_data    <= '0;
            popped_words <= 0;
        end else begin
            if (fifo_pop && fq.size() > 0) begin
                fifo_data    <= fq.pop_front();
                popped_words <= popped_words + 1;
            end
            fifo_empty <= (fq.size() == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fq.push_back(w);
        for (int b = 31; b >= 0; b--) model_bits.push_back(w[b]);
    endtask

    function automatic logic [14:0] take_bits(input int n);
        logic [14:0] d = '0;
        for (int i = 0; i < n; i++) d = {d[13:0], model_bits.pop_front()};
        return d;
    endfunction

    // One clock: sample at the falling edge and check every response in order.
    task automatic tick();
        rsp_t e;
        @(negedge clock);
        if (reset) begin
            if (pushout) begin
                consumed += int'(lenout);
                check("rsp_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("lenout", lenout, e.len);
                    check("dataout", dataout, e.data);
                end
            end else begin
                check("idle_lenout", lenout, 0);
                check("idle_dataout", dataout, 0);
            end
            if (fifo_pop) check("pop_budget", ((popped_words + 1) * 32 - consumed) <= 64, 1);
        end
    endtask

    task automatic do_reset();
        reqin  = 1'b0;
        reqlen = '0;
        reset  = 1'b0;
        fq.delete();
        exp_q.delete();
        model_bits.delete();
        consumed = 0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic request(input logic [3:0] len, input logic [14:0] data, input bit immediate,
                           input string name);
        rsp_t e;
        e.len  = len;
        e.data = data;
        exp_q.push_back(e);
        reqin  = 1'b1;
        reqlen = len;
        tick();
        reqin  = 1'b0;
        if (immediate) check(name, pushout, 1);
    endtask

    task automatic wait_drain(input int max_cycles, input string name);
        for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) tick();
        check(name, exp_q.size(), 0);
    endtask

    rsp_t        t1[8];
    rsp_t        t2[5];
    rsp_t        e;
    logic [3:0]  len;

    initial begin
        t1[0] = '{4'd4, 15'h000A}; t1[1] = '{4'd4, 15'h0005};
        t1[2] = '{4'd4, 15'h000A}; t1[3] = '{4'd4, 15'h0005};
        t1[4] = '{4'd4, 15'h000A}; t1[5] = '{4'd4, 15'h0005};
        t1[6] = '{4'd4, 15'h000A}; t1[7] = '{4'd4, 15'h0005};
        t2[0] = '{4'd15, 15'h7FFF}; t2[1] = '{4'd15, 15'h4000};
        t2[2] = '{4'd15, 15'h0246}; t2[3] = '{4'd15, 15'h4567};
        t2[4] = '{4'd4, 15'h0008};

        // Reset state
        #2 reset = 1'b0;
        repeat (2) tick();
        check("rst_fifo_pop", fifo_pop, 0);
        check("rst_req_busy", req_busy, 0);
        check("rst_pushout", pushout, 0);
        check("rst_lenout", lenout, 0);
        check("rst_dataout", dataout, 0);
        check("rst_err", err, 0);
        reset = 1'b1;

        // T1: nibble stream with one-cycle latency
        push_word(32'hA5A5_A5A5);
        repeat (10) tick();
        for (int i = 0; i < 8; i++) request(t1[i].len, t1[i].data, 1'b1, "t1_latency");
        wait_drain(5, "t1_drain");

        // T2: 15-bit reads straddling the word boundary, then the 4-bit remainder
        do_reset();
        push_word(32'hFFFF_0000);
        push_word(32'h1234_5678);
        repeat (12) tick();
        for (int i = 0; i < 5; i++) request(t2[i].len, t2[i].data, 1'b1, "t2_latency");
        reqin  = 1'b1;
        reqlen = 4'd1;
        tick();
        reqin  = 1'b0;
        check("t2_empty_busy", req_busy, 1);
        check("t2_empty_nopush", pushout, 0);

        // T3: request on an empty FIFO waits, then completes once a word lands
        do_reset();
        request(4'd7, 15'h0040, 1'b0, "t3_req");
        for (int i = 0; i < 5; i++) begin
            check("t3_busy", req_busy, 1);
            check("t3_nopush", pushout, 0);
            tick();
        end
        push_word(32'h8000_0000);
        wait_drain(20, "t3_rsp");
        tick();
        check("t3_idle", req_busy, 0);

        // T4: 15-bit reads every other cycle, then random lengths, against the bit model
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            reqin = 1'b0;
            if (fq.size() < 2 && (cyc < 400 || $urandom_range(0, 3) != 0)) push_word($urandom());
            if (cyc % 2 == 0 && !req_busy) begin
                len = (cyc < 400) ? 4'd15 : 4'($urandom_range(0, 15));
                if (model_bits.size() >= int'(len)) begin
                    e.len  = len;
                    e.data = take_bits(int'(len));
                    exp_q.push_back(e);
                    reqin  = 1'b1;
                    reqlen = len;
                end
            end
            tick();
        end
        reqin = 1'b0;
        wait_drain(200, "t4_drain");

        // T5: zero-length read, then a stray request while waiting
        do_reset();
        push_word(32'hC3C3_C3C3);
        repeat (10) tick();
        request(4'd0, 15'h0000, 1'b1, "t5_zero");
        request(4'd8, 15'h00C3, 1'b1, "t5_after_zero");
        request(4'd15, 15'h61E1, 1'b1, "t5_fifteen");
        request(4'd15, 15'h70FF, 1'b0, "t5_wait");
        check("t5_busy", req_busy, 1);
        check("t5_err_clear", err, 0);
        reqin  = 1'b1;
        reqlen = 4'd3;
        tick();
        reqin  = 1'b0;
        check("t5_err_set", err, 1);
        check("t5_stray_nopush", pushout, 0);
        push_word(32'hFFFF_FFFF);
        wait_drain(20, "t5_rsp");
        repeat (5) tick();
        check("t5_idle", req_busy, 0);
        check("t5_err_sticky", err, 1);

        // T6: reset while waiting with a pop in flight, then a clean restart
        do_reset();
        reqin  = 1'b1;
        reqlen = 4'd7;
        tick();
        reqin  = 1'b1;
        reqlen = 4'd2;
        tick();
        reqin  = 1'b0;
        check("t6_err", err, 1);
        push_word(32'hDEAD_BEEF);
        for (int i = 0; i < 20 && !fifo_pop; i++) tick();
        check("t6_pop_seen", fifo_pop, 1);
        reset = 1'b0;
        #1;
        check("t6_rst_fifo_pop", fifo_pop, 0);
        check("t6_rst_req_busy", req_busy, 0);
        check("t6_rst_pushout", pushout, 0);
        check("t6_rst_lenout", lenout, 0);
        check("t6_rst_dataout", dataout, 0);
        check("t6_rst_err", err, 0);
        do_reset();
        push_word(32'h9ABC_DEF0);
        repeat (10) tick();
        request(4'd12, 15'h09AB, 1'b1, "t6_restart");
        request(4'd12, 15'h0CDE, 1'b1, "t6_restart2");
        wait_drain(5, "t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
